// File: rtl/ram_stream_reader.sv
// Block reader for the simple dual-port RAM: walks an address range and
// returns the words as a valid/ready stream with a per-command last flag.
module ram_stream_reader #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic [AW-1:0]     start_addr,
    input  logic [AW:0]       length,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     rd_addr,
    input  logic [DWIDTH-1:0] rd_data,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW:0]   ONE      = (AW + 1)'(1);
    localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

    state_t state;
    state_t state_next;

    logic [AW-1:0] addr;
    logic [AW-1:0] last_addr;
    logic [AW:0]   remaining;
    logic          inflight;
    logic          inflight_last;

    logic [DWIDTH-1:0] buf_data [3];
    logic              buf_last [3];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [1:0]        occ;
    logic [1:0]        occ_next;
    logic [2:0]        occ_sum;

    logic accept;
    logic issue;
    logic push;
    logic pop;
    logic done_next;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == LAST_ADR) ? '0 : a + AW'(1);
    endfunction

    function automatic logic [1:0] next_slot(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue credit counts only registered occupancy plus the read in flight,
    // so the buffer can never overflow even if the consumer stalls.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        occ_sum    = {1'b0, occ} + {2'b00, inflight};
        push       = inflight;
        pop        = m_axis_tvalid && m_axis_tready;
        occ_next   = occ + {1'b0, push} - {1'b0, pop};
        case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        accept     = 1'b1;
                        state_next = READ;
                    end else begin
                        done_next  = 1'b1;
                    end
                end
            end
            READ: begin
                issue = (remaining != '0) && (occ_sum < 3'd3);
                if (issue && remaining == ONE) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the final beat pops so done lands one cycle after it.
                if (!inflight && occ_next == 2'd0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            addr          <= '0;
            last_addr     <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= done_next;
            inflight      <= issue;
            inflight_last <= issue && (remaining == ONE);
            if (accept) begin
                addr      <= start_addr;
                remaining <= length;
            end else if (issue) begin
                addr      <= next_addr(addr);
                remaining <= remaining - ONE;
                last_addr <= addr;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            occ    <= 2'd0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= rd_data;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= next_slot(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_slot(rd_ptr);
            end
            occ <= occ_next;
        end
    end

    assign rd_addr       = issue ? addr : last_addr;
    assign busy          = (state != IDLE);
    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tdata  = buf_data[rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid && buf_last[rd_ptr];

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side master for the team's simple dual-port RAM.
- On a start command it walks a block of RAM addresses and drives the RAM read port (rd_addr, 1-cycle registered read data).
- It returns the words as a stream with valid/ready backpressure and a last flag.
- It sits between a RAM filled by a writer and any downstream stream consumer.

Parameters:
DWIDTH, 16, data word width; must match the RAM.
DEPTH, 256, RAM depth in words; address width AW = $clog2(DEPTH).

Ports:
aclk  input  1  clock; all logic on rising edge.
areset  input  1  synchronous, active-high reset.
start  input  1  command strobe; sampled only when busy=0.
start_addr  input  AW  first RAM address of the block.
length  input  AW+1  number of words to read, 0..DEPTH.
busy  output  1  high while a command is in progress.
done  output  1  one-cycle pulse when a command completes.
rd_addr  output  AW  to the RAM read address.
rd_data  input  DWIDTH  from the RAM data output; valid one cycle after rd_addr is sampled.
m_axis_tdata  output  DWIDTH  stream data.
m_axis_tvalid  output  1  stream valid.
m_axis_tready  input  1  stream ready.
m_axis_tlast  output  1  high on the final beat of a command.

Behaviour:
- Reset (areset=1 at an edge): state IDLE.
  - busy=0, done=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, rd_addr=0.
  - Buffer and in-flight counters are cleared.
  - Reset mid-command aborts it: in-flight read data is discarded, no done pulse.
- States: IDLE, READ, DRAIN.
  - IDLE: if start=1 and length!=0, latch start_addr into the address counter and length into remaining; go to READ; busy=1 from the next cycle.
  - IDLE with start=1 and length=0: stay IDLE, pulse done in the next cycle, never assert busy or tvalid.
  - READ: issue one read per cycle while remaining>0 and (occ + inflight) < 3.
    - occ = output buffer occupancy (0..3); inflight = reads issued last cycle (0..1). Both are registered values; there is no credit for a pop in the same cycle.
    - An issue presents rd_addr = address counter, then addr <= addr+1 modulo DEPTH (wraps DEPTH-1 -> 0), remaining--.
    - When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until occ=0 and inflight=0. Then go to IDLE; busy=0 and done=1 in that same cycle (the cycle after the final handshake).
- rd_addr holds its last value when no issue occurs; the RAM may see repeated addresses, and the result is ignored.
- Read pipeline:
  - An issue in cycle t means rd_data is valid in t+1.
  - It is written into the 3-entry FIFO buffer at the end of t+1 and is visible on m_axis_tdata in t+2.
- Stream:
  - m_axis_tvalid = (occ>0); m_axis_tdata = buffer head.
  - A beat transfers when tvalid and tready are both 1.
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - Simultaneous push and pop in one cycle leaves occ unchanged.
- tlast is tagged per entry: set on the word issued with remaining==1.
- Latency: start sampled at edge of cycle 0 -> first rd_addr issued in cycle 1 -> first tvalid in cycle 3.
- Throughput: with tready held 1, one beat per cycle with no bubbles.
- start while busy=1 is ignored.
- RAM writes during a command are not blocked; each beat returns the RAM contents at its read-sample edge.
- Data is never dropped or duplicated under any tready pattern.

Test Plan:
1. RAM[a]=3*a; start_addr=0x10, length=4, tready=1 -> beats 0x30,0x33,0x36,0x39 in cycles 3-6, tlast only on 0x39; done=1 and busy=0 in cycle 7.
2. Wrap: start_addr=0xFE, length=4 -> rd_addr sequence 0xFE,0xFF,0x00,0x01; data RAM[0xFE],RAM[0xFF],RAM[0x00],RAM[0x01], tlast on the 4th beat.
3. Backpressure: length=8, tready=0 in cycles 3-10 -> tdata stable at the first word; occ+inflight saturates at 3 and no further rd_addr issues; after release all 8 words arrive in order, each once.
4. length=0 -> busy stays 0, tvalid never asserts, done pulses in cycle 1; length=256 from 0x80 -> 256 beats covering every address once, tlast on RAM[0x7F].
5. start pulsed again in cycle 2 of a length=4 command with a different start_addr -> ignored; only the original 4 words are produced, single done.
6. areset=1 in cycle 5 of a length=10 command -> all outputs at reset values next cycle, no done pulse; a new start then runs cleanly from its own start_addr.
